ring_counter_ctrl: RTL and testbench
====================================

Name: ring_counter_ctrl

Overview:
Wishbone-controlled sequencer for the user-area 4-bit ring counter: owns the ring register and decides when it loads, rotates and stops.
- Firmware on the management SoC sets seed, direction, step rate and step count, issues START/STOP, and polls STATUS or takes an IRQ.
- Output drives the user GPIO count bits in place of the free-running counter.

Parameters:
PRESC_W, 16, width of prescaler reload and counter
STEP_W, 16, width of step-count register and remaining counter

Ports:
wb_clk_i  input  1  single clock for all logic
wb_rst_i  input  1  reset, synchronous, active-low (0 = reset)
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  write enable
wbs_sel_i  input  4  byte selects
wbs_adr_i  input  32  byte address; bits [3:2] select register, bits [7:4] must be 0
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  single-cycle acknowledge
wbs_dat_o  output  32  read data, valid while ack is high
count_out  output  4  ring value
irq  output  1  level interrupt

Behaviour:
Register map:
- 0x00 CTRL: bit0 START (pulse, reads 0); bit1 STOP (pulse, reads 0); bit2 DIR (0 = left {q[2:0],q[3]}, 1 = right {q[0],q[3:1]}); bit3 CONT (1 = run forever); bit4 IRQ_EN; [11:8] SEED.
- 0x04 PRESCALE[15:0]: one rotation every PRESCALE+1 cycles.
- 0x08 STEPS[15:0]: rotations per one-shot run.
- 0x0C STATUS (read): bit0 BUSY, bit1 DONE (sticky; write 1 to bit1 clears it), [11:8] ring, [31:16] remaining steps.

Wishbone:
- ack rises the cycle after stb&cyc with ack low; held one cycle only; back-to-back transfers take 2 cycles each.
- Writes commit on the same edge ack rises, honouring byte selects.
- Address with nonzero [7:4]: acked, reads 0, write ignored.

Reset (wb_rst_i==0 at a clock edge):
- ring=0001, state IDLE, all registers 0, ack=0, dat_o=0, irq=0.
- Reset mid-run aborts immediately to these values.

FSM states IDLE, RUN, DONE:
- IDLE/DONE + START:
  - ring<=SEED (SEED==0 loads 0001); remaining<=STEPS; presc_cnt<=PRESCALE; DONE flag cleared.
  - STEPS==0 and CONT==0: go to DONE directly with no rotation and DONE set.
  - Otherwise go to RUN.
- RUN tick:
  - presc_cnt decrements each cycle; at 0 the ring rotates per current DIR and presc_cnt reloads from current PRESCALE.
  - First rotation occurs PRESCALE+1 cycles after entering RUN.
  - If CONT==0, remaining decrements on each rotation; when it reaches 0: go to DONE, set DONE.
- In CONT mode, remaining holds its value and the run never ends.
- RUN + STOP: go to IDLE, ring holds its value, DONE not set.
- START in RUN: ignored.
- START and STOP in the same write: STOP wins.
- Writes during RUN:
  - DIR/CONT take effect at the next tick.
  - PRESCALE takes effect at the next reload.
  - STEPS/SEED are used only at the next START.
- irq = DONE & IRQ_EN, registered. Clearing DONE or IRQ_EN drops irq the next cycle.
- count_out = ring, registered; never takes a non-one-hot value.

Decomposition:
- Package ring_ctrl_pkg: register offsets, CTRL/STATUS bit positions, FSM state enum, RING_RESET=4'b0001.
- Sub-module ring_tick_gen: prescaler with reload, enable and tick output.

Test Plan:
- Reset: hold wb_rst_i=0 for 2 cycles -> count_out=0001, irq=0, STATUS reads 0x00000100.
- One-shot left: PRESCALE=0, STEPS=5, CTRL=0x111 -> count_out steps 0010,0100,1000,0001,0010 on consecutive cycles; DONE=1, irq=1; W1C bit1 -> irq=0.
- Right with prescale: PRESCALE=3, STEPS=3, CTRL=0x105 -> rotations every 4 cycles: 1000,0100,0010; first rotation 4 cycles after START ack.
- STOP mid-run: CONT=1, PRESCALE=0, STOP after 2 rotations -> count_out frozen at 0100, BUSY=0, DONE=0; a further START is accepted.
- Edge cases:
  - STEPS=0 START -> DONE next cycle with ring=SEED.
  - SEED=0 -> ring=0001.
  - START+STOP written together -> stays IDLE.
  - Write with sel=4'b0001 to PRESCALE -> only [7:0] updated.
- Reset mid-run, with unmapped address 0x10 -> reset restores ring=0001 and IDLE; access to 0x10 acked with read 0 and no state change.

Source files
------------

// File: rtl/ring_ctrl_pkg.sv
// rtl/ring_ctrl_pkg.sv - register map, bit positions, FSM states and helpers for ring_counter_ctrl
package ring_ctrl_pkg;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_PRESCALE = 2'd1;
  localparam logic [1:0] REG_STEPS    = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  localparam int CTRL_START    = 0;
  localparam int CTRL_STOP     = 1;
  localparam int CTRL_DIR      = 2;
  localparam int CTRL_CONT     = 3;
  localparam int CTRL_IRQ_EN   = 4;
  localparam int CTRL_SEED_LSB = 8;

  localparam int STAT_BUSY       = 0;
  localparam int STAT_DONE       = 1;
  localparam int STAT_RING_LSB   = 8;
  localparam int STAT_REMAIN_LSB = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] RING_RESET = 4'b0001;

  // dir 0 rotates toward the MSB, dir 1 toward the LSB
  function automatic logic [3:0] ring_rotate(input logic [3:0] q, input logic dir);
    return dir ? {q[0], q[3:1]} : {q[2:0], q[3]};
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ring_tick_gen.sv
// rtl/ring_tick_gen.sv - reloadable down-counting prescaler producing one tick per reload period
module ring_tick_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] reload,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = enable && (cnt == '0);

  // reload samples the live value so a new prescale lands at the next wrap
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= reload;
    end else if (enable) begin
      cnt <= (cnt == '0) ? reload : cnt - W'(1);
    end
  end

endmodule

// File: rtl/ring_counter_ctrl.sv
// rtl/ring_counter_ctrl.sv - Wishbone-controlled sequencer owning the 4-bit ring counter
module ring_counter_ctrl #(
  parameter int PRESC_W = 16,
  parameter int STEP_W  = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  count_out,
  output logic        irq
);
  import ring_ctrl_pkg::*;

  logic [1:0]         state;
  logic [3:0]         ring;
  logic               dir, cont, irq_en, done_flag;
  logic [3:0]         seed;
  logic [PRESC_W-1:0] prescale;
  logic [STEP_W-1:0]  steps, remaining;

  logic        access, mapped, wr, wr_ctrl, wr_presc, wr_steps, wr_status;
  logic        start_req, stop_req, start_go, cont_n, tick;
  logic [1:0]  reg_sel;
  logic [3:0]  seed_n, seed_eff;
  logic [31:0] ctrl_cur, ctrl_new, presc_merged, steps_merged, rdata;
  logic        unused_ok;

  assign access    = wbs_stb_i && wbs_cyc_i && !wbs_ack_o;
  assign mapped    = (wbs_adr_i[7:4] == 4'd0);
  assign reg_sel   = wbs_adr_i[3:2];
  assign wr        = access && wbs_we_i && mapped;
  assign wr_ctrl   = wr && (reg_sel == REG_CTRL);
  assign wr_presc  = wr && (reg_sel == REG_PRESCALE);
  assign wr_steps  = wr && (reg_sel == REG_STEPS);
  assign wr_status = wr && (reg_sel == REG_STATUS);

  assign ctrl_cur     = {20'h0, seed, 3'b000, irq_en, cont, dir, 2'b00};
  assign ctrl_new     = byte_merge(ctrl_cur, wbs_dat_i, wbs_sel_i);
  assign presc_merged = byte_merge(32'(prescale), wbs_dat_i, wbs_sel_i);
  assign steps_merged = byte_merge(32'(steps), wbs_dat_i, wbs_sel_i);

  // pulse bits read back as 0, so the merge yields 1 only on a selected written 1
  assign start_req = wr_ctrl && ctrl_new[CTRL_START];
  assign stop_req  = wr_ctrl && ctrl_new[CTRL_STOP];
  assign start_go  = start_req && !stop_req && (state != ST_RUN);
  assign cont_n    = wr_ctrl ? ctrl_new[CTRL_CONT] : cont;
  assign seed_n    = wr_ctrl ? ctrl_new[CTRL_SEED_LSB +: 4] : seed;
  assign seed_eff  = $onehot(seed_n) ? seed_n : RING_RESET;

  assign count_out = ring;
  assign unused_ok = &{1'b0, wbs_adr_i[31:8], wbs_adr_i[1:0], ctrl_new, presc_merged, steps_merged};

  ring_tick_gen #(.W(PRESC_W)) u_tick (
    .clk    (wb_clk_i),
    .resetn (wb_rst_i),
    .load   (start_go),
    .enable (state == ST_RUN),
    .reload (prescale),
    .tick   (tick)
  );

  always_comb begin
    rdata = '0;
    if (mapped) begin
      case (reg_sel)
        REG_CTRL:     rdata = ctrl_cur;
        REG_PRESCALE: rdata = 32'(prescale);
        REG_STEPS:    rdata = 32'(steps);
        default: begin
          rdata[STAT_BUSY]                = (state == ST_RUN);
          rdata[STAT_DONE]                = done_flag;
          rdata[STAT_RING_LSB +: 4]       = ring;
          rdata[STAT_REMAIN_LSB +: 16]    = 16'(remaining);
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state     <= ST_IDLE;
      ring      <= RING_RESET;
      dir       <= 1'b0;
      cont      <= 1'b0;
      irq_en    <= 1'b0;
      seed      <= 4'd0;
      prescale  <= '0;
      steps     <= '0;
      remaining <= '0;
      done_flag <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq       <= 1'b0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= (access && !wbs_we_i) ? rdata : '0;
      irq       <= done_flag && irq_en;

      if (wr_ctrl) begin
        dir    <= ctrl_new[CTRL_DIR];
        cont   <= ctrl_new[CTRL_CONT];
        irq_en <= ctrl_new[CTRL_IRQ_EN];
        seed   <= seed_n;
      end
      if (wr_presc) prescale <= presc_merged[PRESC_W-1:0];
      if (wr_steps) steps <= steps_merged[STEP_W-1:0];
      if (wr_status && wbs_sel_i[0] && wbs_dat_i[STAT_DONE]) done_flag <= 1'b0;

      case (state)
        ST_RUN: begin
          if (stop_req) begin
            state <= ST_IDLE;
          end else if (tick) begin
            ring <= ring_rotate(ring, dir);
            if (!cont) begin
              // <=1 also covers a run started in CONT mode with zero steps
              if (remaining <= STEP_W'(1)) begin
                remaining <= '0;
                state     <= ST_DONE;
                done_flag <= 1'b1;
              end else begin
                remaining <= remaining - STEP_W'(1);
              end
            end
          end
        end
        ST_IDLE, ST_DONE: begin
          if (start_go) begin
            ring      <= seed_eff;
            remaining <= steps;
            if ((steps == '0) && !cont_n) begin
              state     <= ST_DONE;
              done_flag <= 1'b1;
            end else begin
              state     <= ST_RUN;
              done_flag <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_counter_ctrl.sv
// tb/tb_ring_counter_ctrl.sv - self-checking bench for ring_counter_ctrl
module tb_ring_counter_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [3:0]  count_out;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  ring_counter_ctrl #(.PRESC_W(16), .STEP_W(16)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .count_out (count_out),
    .irq       (irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // returns #1 after the edge on which the transfer committed
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd);
    logic acked;
    acked = 1'b0;
    rd = '0;
    @(negedge wb_clk_i);
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    repeat (8) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        acked = 1'b1;
        rd = wbs_dat_o;
        break;
      end
    end
    check_val("ack", 32'(acked), 32'd1);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, dat, sel, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rd);
    wb_xfer(1'b0, adr, 32'h0, 4'hF, rd);
  endtask

  // ring value t cycles after START: seed's one-hot position advanced by the rotations done so far
  function automatic logic [3:0] model_ring(input logic [3:0] seed, input bit dir,
                                            input int presc, input int steps, input int t);
    int pos, k;
    logic [3:0] one;
    one = 4'b0001;
    pos = 0;
    for (int i = 0; i < 4; i++) if (seed[i]) pos = i;
    k = t / (presc + 1);
    if (k > steps) k = steps;
    pos = dir ? ((pos - (k % 4) + 4) % 4) : ((pos + k) % 4);
    return one << pos;
  endfunction

  task automatic run_oneshot(input logic [3:0] seed, input bit dir, input int presc,
                             input int steps, input bit ien);
    logic [31:0] ctrl, st;
    logic [3:0]  fin;
    int span;
    wb_write(32'h4, 32'(presc), 4'hF);
    wb_write(32'h8, 32'(steps), 4'hF);
    ctrl = {20'h0, seed, 3'b000, ien, 1'b0, dir, 2'b01};
    wb_write(32'h0, ctrl, 4'hF);
    span = steps * (presc + 1) + 3;
    for (int t = 1; t <= span; t++) begin
      @(posedge wb_clk_i); #1;
      check_val("ring_seq", 32'(count_out), 32'(model_ring(seed, dir, presc, steps, t)));
    end
    fin = model_ring(seed, dir, presc, steps, span);
    wb_read(32'hC, st);
    check_val("status_done", st, {16'h0, 4'h0, fin, 6'h0, 1'b1, 1'b0});
    check_val("irq_done", 32'(irq), 32'(ien));
    wb_write(32'hC, 32'h2, 4'b0001);
    @(posedge wb_clk_i); #1;
    check_val("irq_w1c", 32'(irq), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  seeds [5];
    seeds[0] = 4'h0; seeds[1] = 4'h1; seeds[2] = 4'h2; seeds[3] = 4'h4; seeds[4] = 4'h8;

    repeat (2) @(posedge wb_clk_i);
    #1;
    check_val("rst_ring", 32'(count_out), 32'h1);
    check_val("rst_irq", 32'(irq), 32'h0);
    check_val("rst_ack", 32'(wbs_ack_o), 32'h0);
    check_val("rst_dat", wbs_dat_o, 32'h0);
    @(negedge wb_clk_i) wb_rst_i = 1'b1;
    wb_read(32'hC, rd);
    check_val("rst_status", rd, 32'h0000_0100);
    @(posedge wb_clk_i); #1;
    check_val("ack_one_cycle", 32'(wbs_ack_o), 32'h0);

    // START and STOP together: STOP wins
    wb_write(32'h8, 32'd4, 4'hF);
    wb_write(32'h0, 32'h803, 4'hF);
    repeat (3) @(posedge wb_clk_i);
    #1;
    check_val("startstop_ring", 32'(count_out), 32'h1);
    wb_read(32'hC, rd);
    check_val("startstop_status", rd, 32'h0000_0100);

    run_oneshot(4'h1, 1'b0, 0, 5, 1'b1);
    run_oneshot(4'h1, 1'b1, 3, 3, 1'b0);

    // continuous run stopped after two rotations
    wb_write(32'h4, 32'h0, 4'hF);
    wb_write(32'h0, 32'h109, 4'hF);
    repeat (2) @(posedge wb_clk_i);
    wb_write(32'h0, 32'h2, 4'hF);
    repeat (3) @(posedge wb_clk_i);
    #1;
    check_val("stop_ring", 32'(count_out), 32'h4);
    wb_read(32'hC, rd);
    check_val("stop_status", rd, 32'h0003_0400);
    wb_write(32'h0, 32'h101, 4'hF);
    wb_read(32'hC, rd);
    check_val("restart_busy", rd & 32'h3, 32'h1);
    repeat (8) @(posedge wb_clk_i);
    #1;
    check_val("restart_ring", 32'(count_out), 32'h8);
    wb_read(32'hC, rd);
    check_val("restart_status", rd, 32'h0000_0802);

    // zero steps: straight to DONE holding the seed
    wb_write(32'h8, 32'h0, 4'hF);
    wb_write(32'h0, 32'h401, 4'hF);
    @(posedge wb_clk_i); #1;
    check_val("steps0_ring", 32'(count_out), 32'h4);
    wb_read(32'hC, rd);
    check_val("steps0_status", rd, 32'h0000_0402);
    wb_write(32'h0, 32'h001, 4'hF);
    @(posedge wb_clk_i); #1;
    check_val("seed0_ring", 32'(count_out), 32'h1);

    wb_write(32'h4, 32'h1234, 4'hF);
    wb_write(32'h4, 32'hABCD, 4'b0001);
    wb_read(32'h4, rd);
    check_val("presc_sel", rd, 32'h0000_12CD);
    wb_write(32'h0, 32'hA1C, 4'hF);
    wb_read(32'h0, rd);
    check_val("ctrl_readback", rd, 32'h0000_0A1C);

    for (int it = 0; it < 16; it++) begin
      run_oneshot(seeds[$urandom_range(4, 0)], 1'($urandom_range(1, 0)),
                  int'($urandom_range(3, 0)), int'($urandom_range(6, 0)),
                  1'($urandom_range(1, 0)));
    end

    // unmapped access during a continuous run, then reset mid-run
    wb_write(32'h4, 32'h1, 4'hF);
    wb_write(32'h0, 32'h10D, 4'hF);
    wb_write(32'h10, 32'h2, 4'hF);
    wb_read(32'h10, rd);
    check_val("unmapped_read", rd, 32'h0);
    wb_read(32'hC, rd);
    check_val("unmapped_busy", rd & 32'h3, 32'h1);
    @(negedge wb_clk_i) wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check_val("midrst_ring", 32'(count_out), 32'h1);
    check_val("midrst_irq", 32'(irq), 32'h0);
    @(negedge wb_clk_i) wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check_val("midrst_hold", 32'(count_out), 32'h1);
    wb_read(32'hC, rd);
    check_val("midrst_status", rd, 32'h0000_0100);
    wb_read(32'h4, rd);
    check_val("midrst_presc", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
